// File: rtl/data_mem_bridge_if.sv
// data_mem_bridge_if: SRAM-like data bus with addr_ok/data_ok handshake
interface data_mem_bridge_if #(parameter int AW = 32, parameter int DW = 32);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [3:0]    data_wstrb;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: MEM-stage load/store to single-outstanding SRAM-like bus bridge
module data_mem_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic          mem_wr,
  input  logic [1:0]    size,
  input  logic          load_unsigned,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic          stall_o,
  output logic [DW-1:0] rdata_o,
  output logic          rdata_valid,
  output logic          addr_err_load,
  output logic          addr_err_store,
  data_mem_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic lu_q, discard;
  logic active, mis, start, done, disc;
  logic [3:0] wstrb;
  logic [1:0] bsize;
  logic [7:0] b;
  logic [15:0] h;
  logic [DW-1:0] ext;
  always_comb begin
    mis = (size == 2'b01 && addr[1:0] != 2'b00) || (size == 2'b10 && addr[0]);
    active = state == IDLE && mem_en && size != 2'b00 && !flush;
    start = active && !mis;
    addr_err_load = active && mis && !mem_wr;
    addr_err_store = active && mis && mem_wr;
    wstrb = !mem_wr ? 4'b0000 :
            size == 2'b01 ? 4'b1111 :
            size == 2'b10 ? (addr[1] ? 4'b1100 : 4'b0011) :
            4'b0001 << addr[1:0];
    bsize = size == 2'b01 ? 2'd2 : size == 2'b10 ? 2'd1 : 2'd0;
    done = ((state == REQ && bus.data_addr_ok) || state == WAIT) && bus.data_data_ok;
    disc = discard || flush;
    stall_o = state == REQ || state == WAIT || start;
    b = bus.data_rdata[{bus.data_addr[1:0], 3'b000} +: 8];
    h = bus.data_rdata[{bus.data_addr[1], 4'b0000} +: 16];
    ext = bus.data_size == 2'd2 ? bus.data_rdata :
          bus.data_size == 2'd1 ? {{16{!lu_q && h[15]}}, h} :
          {{24{!lu_q && b[7]}}, b};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.data_req <= 1'b0;
      bus.data_wr <= 1'b0;
      bus.data_size <= 2'd0;
      bus.data_addr <= '0;
      bus.data_wdata <= '0;
      bus.data_wstrb <= 4'b0000;
      rdata_o <= '0;
      rdata_valid <= 1'b0;
      lu_q <= 1'b0;
      discard <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          bus.data_req <= 1'b1;
          bus.data_wr <= mem_wr;
          bus.data_size <= bsize;
          bus.data_addr <= addr;
          bus.data_wdata <= wdata;
          bus.data_wstrb <= wstrb;
          lu_q <= load_unsigned;
          discard <= 1'b0;
        end
        REQ, WAIT: begin
          discard <= disc;
          if (state == REQ && bus.data_addr_ok) begin
            bus.data_req <= 1'b0;
            state <= WAIT;
          end
          // a flushed transaction still finishes on the bus but skips DONE
          if (done) begin
            state <= disc ? IDLE : DONE;
            discard <= 1'b0;
            if (!disc && !bus.data_wr) begin
              rdata_o <= ext;
              rdata_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed + randomized transactions against a byte-level reference model
module tb_data_mem_bridge;
  logic clk = 0, rst = 1;
  logic mem_en = 0, mem_wr = 0, load_unsigned = 0, flush = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic stall_o, rdata_valid, addr_err_load, addr_err_store;
  logic [31:0] rdata_o;
  logic [31:0] exp_rdata = 0;
  int checks = 0, passed = 0;
  data_mem_bridge_if bus();
  data_mem_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .flush(flush),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid(rdata_valid),
    .addr_err_load(addr_err_load), .addr_err_store(addr_err_store), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic wr, input logic [1:0] sz, input logic lu, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ad, input int dd, input int fl);
    int nb, acc_c;
    logic m, accepted, fin, flushed;
    logic [31:0] msk, ev;
    logic [3:0] es;
    logic [1:0] esz;
    nb = sz == 2'b01 ? 4 : sz == 2'b10 ? 2 : 1;
    m = (a % nb) != 0;
    es = wr ? 4'(((1 << nb) - 1) << (a % 4)) : 4'b0000;
    esz = nb == 4 ? 2'd2 : nb == 2 ? 2'd1 : 2'd0;
    msk = nb == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 1;
    ev = (rd >> (8 * (a % 4))) & msk;
    if (!lu && nb < 4 && ev[8 * nb - 1]) ev = ev | ~msk;
    step;
    mem_en = 1; mem_wr = wr; size = sz; load_unsigned = lu; addr = a; wdata = wd; flush = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0;
    #1;
    chk("err_load", addr_err_load, m && !wr);
    chk("err_store", addr_err_store, m && wr);
    chk("stall_start", stall_o, !m);
    chk("req_start", bus.data_req, 0);
    if (m) begin
      step;
      mem_en = 0;
      #1;
      chk("mis_req", bus.data_req, 0);
      chk("mis_stall", stall_o, 0);
      return;
    end
    accepted = 0; fin = 0; flushed = 0; acc_c = 0;
    for (int c = 1; c < 100 && !fin; c++) begin
      step;
      flush = (c == fl);
      flushed = flushed || flush;
      bus.data_addr_ok = !accepted && (c - 1 == ad);
      if (bus.data_addr_ok) begin accepted = 1; acc_c = c; end
      bus.data_data_ok = accepted && (c - acc_c == dd);
      bus.data_rdata = bus.data_data_ok ? rd : $urandom;
      fin = bus.data_data_ok;
      #1;
      chk("stall_busy", stall_o, 1);
      chk("rvalid_busy", rdata_valid, 0);
      if (!accepted || c == acc_c) begin
        chk("req", bus.data_req, 1);
        chk("addr", bus.data_addr, a);
        chk("wr", bus.data_wr, wr);
        chk("size", bus.data_size, esz);
        chk("wstrb", bus.data_wstrb, es);
        chk("wdata", bus.data_wdata, wd);
      end else chk("req_wait", bus.data_req, 0);
    end
    if (!fin) chk("timeout", 0, 1);
    step;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; flush = 0;
    mem_en = !flushed;
    if (!wr && !flushed) exp_rdata = ev;
    #1;
    chk("stall_done", stall_o, 0);
    chk("req_done", bus.data_req, 0);
    chk("rvalid_done", rdata_valid, !wr && !flushed);
    chk("rdata", rdata_o, exp_rdata);
    step;
    mem_en = 0;
    #1;
    chk("rvalid_after", rdata_valid, 0);
    chk("stall_after", stall_o, 0);
    chk("rdata_hold", rdata_o, exp_rdata);
  endtask
  initial begin
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", bus.data_req, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_wstrb", bus.data_wstrb, 0);
    rst = 0;
    step;
    mem_en = 1; size = 2'b00; addr = 32'h100;
    #1;
    chk("size0_stall", stall_o, 0);
    step;
    mem_en = 0;
    #1;
    chk("size0_req", bus.data_req, 0);
    txn(1, 2'b01, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, -1);
    txn(1, 2'b11, 0, 32'h103, 32'h5A5A5A5A, 32'h0, 0, 0, -1);
    txn(0, 2'b11, 0, 32'h102, 32'h0, 32'h00801234, 0, 0, -1);
    txn(0, 2'b11, 1, 32'h102, 32'h0, 32'h00801234, 0, 0, -1);
    txn(0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0, -1);
    txn(0, 2'b01, 0, 32'h200, 32'h0, 32'hCAFEF00D, 3, 2, -1);
    txn(0, 2'b01, 0, 32'h204, 32'h0, 32'h13572468, 0, 2, 2);
    txn(0, 2'b10, 0, 32'h206, 32'h0, 32'h8001_7FFF, 2, 0, 1);
    for (int i = 0; i < 200; i++)
      txn($urandom_range(0, 1), 2'($urandom_range(1, 3)), $urandom_range(0, 1),
          32'h1000 + $urandom_range(0, 255), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 4) == 0 ? $urandom_range(1, 6) : -1);
    step;
    mem_en = 1; mem_wr = 1; size = 2'b01; addr = 32'h300; wdata = 32'h1;
    step;
    mem_en = 0;
    #1;
    chk("midreq_req", bus.data_req, 1);
    rst = 1;
    #1;
    chk("arst_req", bus.data_req, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_addr", bus.data_addr, 0);
    chk("arst_wstrb", bus.data_wstrb, 0);
    chk("arst_rdata", rdata_o, 0);
    step;
    rst = 0;
    #1;
    chk("arst_rvalid", rdata_valid, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Memory-stage bridge directly downstream of the store-data replication mux.
- Takes each load/store request from the MEM stage (address, size code, replicated write data) and builds the byte strobes and bus size.
- Runs a single-outstanding SRAM-like transaction with an addr_ok/data_ok handshake and stalls the pipeline until the transaction completes.
- For loads, returns the selected, sign- or zero-extended data; misaligned accesses are flagged as address errors and never reach the bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed 32; 4 byte lanes).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mem_en  in  1  valid load/store in MEM stage.
- mem_wr  in  1  1 = store, 0 = load.
- size  in  2  01 = word, 10 = half, 11 = byte; 00 = no access, treated as mem_en = 0.
- load_unsigned  in  1  zero-extend loads (LBU/LHU).
- addr  in  AW  byte address.
- wdata  in  DW  store data, already lane-replicated.
- flush  in  1  exception flush of the MEM stage.
- stall_o  out  1  hold the pipeline.
- rdata_o  out  DW  extended load result.
- rdata_valid  out  1  one-cycle pulse when rdata_o is updated.
- addr_err_load  out  1  misaligned load.
- addr_err_store  out  1  misaligned store.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  AW  bus address.
- data_wdata  out  DW  bus write data.
- data_wstrb  out  4  byte strobes.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response done.
- data_rdata  in  DW  read data.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs are 0: data_* outputs, stall_o, rdata_o, rdata_valid, discard flag.
- Misalignment:
  - Word request with addr[1:0] != 0 is misaligned.
  - Half request with addr[0] != 0 is misaligned.
  - addr_err_load / addr_err_store are combinational and asserted only in IDLE with mem_en = 1 and flush = 0.
  - A misaligned request issues no bus request, does not stall, and leaves the state in IDLE.
- Strobes and size:
  - Word: data_wstrb = 1111, data_size = 2.
  - Half: data_wstrb = 0011 when addr[1] = 0, 1100 when addr[1] = 1; data_size = 1.
  - Byte: data_wstrb = 0001 << addr[1:0]; data_size = 0.
  - Loads: data_wstrb = 0000.
  - data_wdata = wdata unchanged.
- FSM, IDLE:
  - Condition to start: mem_en & ~flush & aligned.
  - On that condition, latch addr, size, mem_wr, load_unsigned, wdata and the strobes, then go to REQ.
  - stall_o is asserted combinationally in that same cycle.
  - The bus request first appears next cycle.
- FSM, REQ:
  - data_req = 1, with the latched fields driven on the bus.
  - On data_addr_ok: go to WAIT, or go directly to DONE if data_data_ok is also high that cycle.
  - data_req and all latched fields are held stable until addr_ok.
- FSM, WAIT:
  - data_req = 0.
  - On data_data_ok: for a load, register the extracted data into rdata_o; then go to DONE.
- FSM, DONE:
  - stall_o = 0 and rdata_valid = 1 (loads only).
  - mem_en is ignored, because it still reflects the completing instruction.
  - Next state is IDLE.
- stall_o is 1 in REQ and WAIT, and in IDLE when starting a request; it is 0 otherwise.
- Load extraction uses the latched addr:
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - Sign-extend unless load_unsigned.
  - Word passes through unchanged.
- rdata_o holds its value until the next load completes.
- Flush:
  - In IDLE: suppresses the start and the error flags.
  - In REQ: the request is still held until addr_ok (no withdrawal), and the discard flag is set.
  - In WAIT: the discard flag is set.
  - A discarded transaction completes to IDLE, skipping DONE, with no rdata_valid and no rdata_o update.
  - stall_o stays high until data_ok.
- Latency, no wait states (addr_ok and data_ok both high on the first REQ cycle):
  - Request in cycle 0, bus request in cycle 1, DONE in cycle 2.
  - The pipeline therefore stalls 2 cycles.
- Only one transaction is outstanding at a time; a new request is never issued before data_ok.

Test Plan:
- SW to 0x100, wdata 0xDEADBEEF, addr_ok and data_ok in the same cycle -> data_wstrb = 1111, data_size = 2, data_wr = 1, stall_o for 2 cycles, no rdata_valid.
- SB to 0x103, wdata 0x5A5A5A5A -> data_wstrb = 1000, data_size = 0.
- LB from 0x102, rdata 0x00801234, load_unsigned = 0 -> rdata_o = 0xFFFFFF80 with rdata_valid pulse. Repeat with load_unsigned = 1 -> rdata_o = 0x00000080.
- LH from 0x101 -> addr_err_load = 1, data_req never asserted, stall_o = 0.
- Load with addr_ok delayed 3 cycles and data_ok 2 cycles later:
  - data_req and data_addr stay stable for all 3 cycles.
  - stall_o stays high throughout.
  - rdata_valid pulses once.
- flush during WAIT of an LW -> completes on data_ok with no rdata_valid and rdata_o unchanged. Separately, rst asserted mid-REQ -> all outputs 0 immediately.
